// File: rtl/xbus_arbiter.sv
// Round-robin CPU/DMA bus arbiter with registered grants and programmable dead time.
// Define XBUS_ARB_TIMEOUT_EN to build the hold-time watchdog and TIMEOUT_ERR flag.
module xbus_arbiter #(
  parameter int unsigned TURNAROUND = 1,
  parameter int unsigned TIMEOUT    = 255,
  parameter int unsigned CW         = 8
) (
  input  logic CLK,
  input  logic RESET_N,
  input  logic REQ0,
  input  logic REQ1,
  input  logic CLR_ERR,
  output logic GNT0,
  output logic GNT1,
  output logic BUSY,
  output logic LAST,
  output logic TIMEOUT_ERR
);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, GAP} state_t;

  localparam logic [3:0] GAP_LOAD = 4'(TURNAROUND - 1);

  state_t     state_q, state_d;
  logic [3:0] gap_q, gap_d;
  logic       last_q, last_d;
  logic       gnt0_q, gnt1_q, busy_q;
  logic       req_cur;

`ifdef XBUS_ARB_TIMEOUT_EN
  localparam logic [CW-1:0] HOLD_MAX = CW'(TIMEOUT - 1);

  logic [CW-1:0] hold_q, hold_d;
  logic          err_q, err_d;
  logic          err_set;
`endif

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    last_d  = last_q;
`ifdef XBUS_ARB_TIMEOUT_EN
    err_set = 1'b0;
`endif
    req_cur = (state_q == GRANT1) ? REQ1 : REQ0;
    case (state_q)
      IDLE: begin
        // On a tie the requester that did not hold the bus last wins.
        if (REQ0 && (!REQ1 || last_q)) begin
          state_d = GRANT0;
          last_d  = 1'b0;
        end else if (REQ1) begin
          state_d = GRANT1;
          last_d  = 1'b1;
        end
      end
      GRANT0, GRANT1: begin
        if (!req_cur) begin
          state_d = GAP;
          gap_d   = GAP_LOAD;
        end
`ifdef XBUS_ARB_TIMEOUT_EN
        else if (hold_q == HOLD_MAX) begin
          state_d = GAP;
          gap_d   = GAP_LOAD;
          err_set = 1'b1;
        end
`endif
      end
      GAP: begin
        if (gap_q == 4'd0) state_d = IDLE;
        else               gap_d   = gap_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      gap_q   <= 4'd0;
      last_q  <= 1'b1;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      last_q  <= last_d;
      gnt0_q  <= (state_d == GRANT0);
      gnt1_q  <= (state_d == GRANT1);
      busy_q  <= (state_d != IDLE);
    end
  end

`ifdef XBUS_ARB_TIMEOUT_EN
  always_comb begin
    hold_d = '0;
    if ((state_q == GRANT0 || state_q == GRANT1) && state_d == state_q)
      hold_d = hold_q + 1'b1;
  end

  // A new timeout takes priority over a clear on the same edge.
  assign err_d = err_set | (err_q & ~CLR_ERR);

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      hold_q <= '0;
      err_q  <= 1'b0;
    end else begin
      hold_q <= hold_d;
      err_q  <= err_d;
    end
  end

  assign TIMEOUT_ERR = err_q;
`else
  logic unused_cfg;
  assign unused_cfg  = CLR_ERR ^ (TIMEOUT == CW);
  assign TIMEOUT_ERR = 1'b0;
`endif

  assign GNT0 = gnt0_q;
  assign GNT1 = gnt1_q;
  assign BUSY = busy_q;
  assign LAST = last_q;

endmodule

// File: tb/tb_xbus_arbiter.sv
// Bench for xbus_arbiter: two instances (dead time 1 and 3) share stimulus and are
// compared against a cycle-level ownership model; XBUS_ARB_TIMEOUT_EN selects TIMEOUT=4.
module tb_xbus_arbiter;

`ifdef XBUS_ARB_TIMEOUT_EN
  localparam int TO    = 4;
  localparam bit TO_EN = 1'b1;
`else
  localparam int TO    = 255;
  localparam bit TO_EN = 1'b0;
`endif
  localparam int TA_A = 1;
  localparam int TA_B = 3;

  logic clk = 1'b0;
  logic rst_n, req0, req1, clr_err;
  logic gnt0_a, gnt1_a, busy_a, last_a, err_a;
  logic gnt0_b, gnt1_b, busy_b, last_b, err_b;
  logic [4:0] out_a, out_b;

  assign out_a = {gnt0_a, gnt1_a, busy_a, last_a, err_a};
  assign out_b = {gnt0_b, gnt1_b, busy_b, last_b, err_b};

  xbus_arbiter #(.TURNAROUND(TA_A), .TIMEOUT(TO), .CW(8)) u_a (
    .CLK(clk), .RESET_N(rst_n), .REQ0(req0), .REQ1(req1), .CLR_ERR(clr_err),
    .GNT0(gnt0_a), .GNT1(gnt1_a), .BUSY(busy_a), .LAST(last_a), .TIMEOUT_ERR(err_a)
  );

  xbus_arbiter #(.TURNAROUND(TA_B), .TIMEOUT(TO), .CW(8)) u_b (
    .CLK(clk), .RESET_N(rst_n), .REQ0(req0), .REQ1(req1), .CLR_ERR(clr_err),
    .GNT0(gnt0_b), .GNT1(gnt1_b), .BUSY(busy_b), .LAST(last_b), .TIMEOUT_ERR(err_b)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: owner (-1 = nobody), remaining dead cycles, cycles the owner has held the bus.
  int m_owner[2];
  int m_cool[2];
  int m_held[2];
  bit m_last[2];
  bit m_err[2];
  int ta[2];

  function automatic void model_edge();
    bit set, rq;
    int w;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_owner[i] = -1; m_cool[i] = 0; m_held[i] = 0; m_last[i] = 1'b1; m_err[i] = 1'b0;
      end else begin
        set = 1'b0;
        if (m_owner[i] >= 0) begin
          rq = (m_owner[i] == 1) ? req1 : req0;
          if (!rq) begin
            m_owner[i] = -1; m_cool[i] = ta[i];
          end else if (TO_EN && m_held[i] == TO) begin
            m_owner[i] = -1; m_cool[i] = ta[i]; set = 1'b1;
          end else begin
            m_held[i]++;
          end
        end else if (m_cool[i] > 0) begin
          m_cool[i]--;
        end else if (req0 || req1) begin
          w = (req0 && req1) ? (m_last[i] ? 0 : 1) : (req0 ? 0 : 1);
          m_owner[i] = w; m_last[i] = (w == 1); m_held[i] = 1;
        end
        if (TO_EN) m_err[i] = set ? 1'b1 : (clr_err ? 1'b0 : m_err[i]);
      end
    end
  endfunction

  function automatic logic [4:0] model_out(input int i);
    return {m_owner[i] == 0, m_owner[i] == 1, (m_owner[i] >= 0) || (m_cool[i] > 0),
            m_last[i], m_err[i]};
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req0 = 1'b1; req1 = 1'b1; clr_err = 1'b0;
    step(); step();
    checks++;
    if (out_a !== 5'b00010) begin
      errors++; $display("FAIL reset_a got %b exp 00010", out_a);
    end
    checks++;
    if (out_b !== 5'b00010) begin
      errors++; $display("FAIL reset_b got %b exp 00010", out_b);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (out_a !== 5'b10100) begin
      errors++; $display("FAIL reset_first_grant got %b exp 10100", out_a);
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (5) step();
  endtask

  task automatic test_single();
    int g1, g0, ba, bb;
    g1 = 0; g0 = 0; ba = 0; bb = 0;
    req1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (i == 0) begin
        checks++;
        if (gnt1_a !== 1'b1) begin
          errors++; $display("FAIL single_latency got %b exp 1", gnt1_a);
        end
      end
      g1 += int'(gnt1_a); g0 += int'(gnt0_a); ba += int'(busy_a); bb += int'(busy_b);
    end
    req1 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      g1 += int'(gnt1_a); g0 += int'(gnt0_a); ba += int'(busy_a); bb += int'(busy_b);
    end
    checks++;
    if (g1 != 5) begin errors++; $display("FAIL single_gnt1_cycles got %0d exp 5", g1); end
    checks++;
    if (g0 != 0) begin errors++; $display("FAIL single_gnt0_cycles got %0d exp 0", g0); end
    checks++;
    if (ba != 5 + TA_A) begin errors++; $display("FAIL single_busy_a got %0d exp %0d", ba, 5 + TA_A); end
    checks++;
    if (bb != 5 + TA_B) begin errors++; $display("FAIL single_busy_b got %0d exp %0d", bb, 5 + TA_B); end
    checks++;
    if (busy_a !== 1'b0) begin errors++; $display("FAIL single_idle_after got %b exp 0", busy_a); end
  endtask

  task automatic test_alternate();
    int seq[$];
    int c0, c1, idle_run, overlap, n;
    bit prev0, prev1;
    c0 = 0; c1 = 0; idle_run = 0; overlap = 0; n = 0; prev0 = 0; prev1 = 0;
    req0 = 1'b1; req1 = 1'b1;
    while (seq.size() < 4 && n < 100) begin
      step(); n++;
      if (gnt0_a && gnt1_a) overlap++;
      if ((gnt0_a && !prev0) || (gnt1_a && !prev1)) begin
        if (seq.size() > 0) begin
          checks++;
          if (idle_run != TA_A + 1) begin
            errors++; $display("FAIL alt_gap got %0d exp %0d", idle_run, TA_A + 1);
          end
        end
        seq.push_back(gnt1_a ? 1 : 0);
      end
      if (!gnt0_a && !gnt1_a) idle_run++; else idle_run = 0;
      if (gnt0_a) begin c0++; if (c0 == 3) begin req0 = 1'b0; c0 = 0; end end
      else req0 = 1'b1;
      if (gnt1_a) begin c1++; if (c1 == 3) begin req1 = 1'b0; c1 = 0; end end
      else req1 = 1'b1;
      prev0 = gnt0_a; prev1 = gnt1_a;
    end
    checks++;
    if (seq.size() != 4) begin errors++; $display("FAIL alt_count got %0d exp 4", seq.size()); end
    for (int k = 0; k < seq.size(); k++) begin
      checks++;
      if (seq[k] != k % 2) begin
        errors++; $display("FAIL alt_order idx %0d got %0d exp %0d", k, seq[k], k % 2);
      end
    end
    checks++;
    if (overlap != 0) begin errors++; $display("FAIL alt_overlap got %0d exp 0", overlap); end
    req0 = 1'b0; req1 = 1'b0;
    repeat (8) step();
  endtask

  task automatic test_reset_mid();
    int n;
    n = 0;
    req0 = 1'b1; req1 = 1'b0;
    step();
    while (gnt0_a !== 1'b1 && n < 10) begin step(); n++; end
    checks++;
    if (gnt0_a !== 1'b1) begin errors++; $display("FAIL mid_grant_up got %b exp 1", gnt0_a); end
    step();
    rst_n = 1'b0;
    step();
    checks++;
    if (out_a !== 5'b00010) begin errors++; $display("FAIL mid_reset_a got %b exp 00010", out_a); end
    checks++;
    if (busy_b !== 1'b0) begin errors++; $display("FAIL mid_reset_busy_b got %b exp 0", busy_b); end
    rst_n = 1'b1; req0 = 1'b0;
    step();
    checks++;
    if (out_a !== 5'b00010) begin errors++; $display("FAIL mid_no_gap got %b exp 00010", out_a); end
  endtask

`ifdef XBUS_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    n = 0;
    req0 = 1'b1; req1 = 1'b1;
    step();
    while (gnt0_a === 1'b1 && n < 20) begin n++; step(); end
    checks++;
    if (n != TO) begin errors++; $display("FAIL timeout_hold got %0d exp %0d", n, TO); end
    checks++;
    if (out_a !== 5'b00101) begin errors++; $display("FAIL timeout_gap got %b exp 00101", out_a); end
    step();
    checks++;
    if (out_a !== 5'b00001) begin errors++; $display("FAIL timeout_idle got %b exp 00001", out_a); end
    step();
    checks++;
    if (out_a !== 5'b01111) begin errors++; $display("FAIL timeout_next got %b exp 01111", out_a); end
  endtask

  task automatic test_clear();
    clr_err = 1'b1;
    step();
    checks++;
    if (out_a !== 5'b01110) begin errors++; $display("FAIL clear_err got %b exp 01110", out_a); end
    clr_err = 1'b0;
    step(); step();
    clr_err = 1'b1;
    step();
    checks++;
    if (out_a !== 5'b00111) begin errors++; $display("FAIL clear_set_wins got %b exp 00111", out_a); end
    step();
    checks++;
    if (err_a !== 1'b0) begin errors++; $display("FAIL clear_again got %b exp 0", err_a); end
    clr_err = 1'b0; req0 = 1'b0; req1 = 1'b0;
    repeat (8) step();
  endtask
`else
  task automatic test_long_hold();
    int hcnt, eseen;
    hcnt = 0; eseen = 0;
    req0 = 1'b1; req1 = 1'b0;
    step();
    for (int i = 0; i < 300; i++) begin
      hcnt += int'(gnt0_a);
      eseen += int'(err_a);
      if (i < 299) step();
    end
    checks++;
    if (hcnt != 300) begin errors++; $display("FAIL long_hold got %0d exp 300", hcnt); end
    checks++;
    if (eseen != 0) begin errors++; $display("FAIL long_err got %0d exp 0", eseen); end
    req0 = 1'b0;
    repeat (8) step();
  endtask
`endif

  task automatic test_random();
    logic [4:0] ea, eb;
    for (int n = 0; n < 1500; n++) begin
      rst_n   = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 3) == 0) req0 = ~req0;
      if ($urandom_range(0, 3) == 0) req1 = ~req1;
      clr_err = ($urandom_range(0, 7) == 0);
      step();
      ea = model_out(0);
      eb = model_out(1);
      checks++;
      if (out_a !== ea) begin errors++; $display("FAIL random_a cycle %0d got %b exp %b", n, out_a, ea); end
      checks++;
      if (out_b !== eb) begin errors++; $display("FAIL random_b cycle %0d got %b exp %b", n, out_b, eb); end
    end
  endtask

  initial begin
    ta[0] = TA_A; ta[1] = TA_B;
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; clr_err = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_alternate();
    test_reset_mid();
`ifdef XBUS_ARB_TIMEOUT_EN
    test_timeout();
    test_clear();
`else
    test_long_hold();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/xbus_arbiter.md
Name: xbus_arbiter

Overview:
Two-requester round-robin arbiter that shares a single bus/memory port between the CPU and a DMA requester. Each grant is registered, and a programmable dead-time separates successive grants. An optional watchdog forces the release of a grant that is held too long. Built from the same registered-flop primitives as the rest of the board logic; it sits between the requesters and the bus-drive enables.

Parameters:
TURNAROUND, 1, dead cycles between grant release and next grant; legal 1..15
TIMEOUT, 255, max cycles a grant may be held (watchdog); legal 2..2^CW-1
CW, 8, width of hold counter

Ports:
CLK  input  1  system clock, all state changes on rising edge
RESET_N  input  1  synchronous active-low reset, sampled on rising CLK
REQ0  input  1  request from requester 0 (CPU), level, held until done
REQ1  input  1  request from requester 1 (DMA), level, held until done
CLR_ERR  input  1  clears TIMEOUT_ERR
GNT0  output  1  grant to requester 0
GNT1  output  1  grant to requester 1
BUSY  output  1  high while granted or in turnaround
LAST  output  1  index of most recent grantee
TIMEOUT_ERR  output  1  sticky: a grant was force-released

Behaviour:
- All outputs registered. No combinational path from input to output.
- Reset: RESET_N low at a CLK edge gives state IDLE, GNT0=GNT1=0, BUSY=0, LAST=1 (so requester 0 wins the first tie), TIMEOUT_ERR=0, hold and gap counters 0. Reset during GRANT or GAP drops the grant at that same edge; no turnaround is applied.
- States: IDLE, GRANT0, GRANT1, GAP.
- IDLE:
  - Only REQ0 high: go to GRANT0.
  - Only REQ1 high: go to GRANT1.
  - Both high: grant the requester != LAST.
  - Neither high: stay in IDLE.
  - On grant: LAST <= grantee, hold counter <= 0.
  - Latency: REQ sampled high at edge n in IDLE gives GNT high from edge n.
- GRANTx, REQx sampled high: stay, hold counter +1.
- GRANTx, REQx sampled low: GNTx <= 0, go to GAP, gap counter <= TURNAROUND-1.
- Other requester's REQ is ignored while in GRANT.
- GAP: GNT0=GNT1=0, BUSY=1, gap counter decrements each edge. At 0, go to IDLE. IDLE arbitrates on the following edge, so minimum release-to-next-grant is TURNAROUND+1 edges.
- BUSY=1 in GRANT0, GRANT1 and GAP; 0 in IDLE.
- GNT0 and GNT1 never high simultaneously.
- Round robin: with both requesters continuously requesting and releasing, grants strictly alternate.
- TIMEOUT_ERR set/clear: CLR_ERR high clears it at the edge; if set and clear occur on the same edge, set wins.

Optional Feature:
Macro XBUS_ARB_TIMEOUT_EN.
- Defined:
  - In GRANTx, when the hold counter == TIMEOUT-1 and REQx is still high at the edge, force a release: GNTx <= 0, TIMEOUT_ERR <= 1, go to GAP.
  - GNT is therefore high at most TIMEOUT cycles per grant.
  - LAST stays at the offender, so the other requester wins the next tie.
  - The offender may be regranted if it is the sole requester.
- Not defined:
  - The hold counter is not built.
  - A grant is held until REQ drops.
  - TIMEOUT_ERR is tied to 0 and CLR_ERR is ignored.

Test Plan:
1. Reset: hold RESET_N=0 for 2 edges with REQ0=REQ1=1 -> GNT0=GNT1=0, BUSY=0, LAST=1, TIMEOUT_ERR=0. Release reset -> GNT0=1 after the first edge.
2. Single requester, TURNAROUND=1: REQ1 high for 5 cycles then low -> GNT1 high 5 cycles, BUSY high 6 cycles, IDLE after.
3. Simultaneous, both REQ held and each dropped for 1 cycle after 3 granted cycles -> grant sequence 0,1,0,1. GNT0 and GNT1 never overlap, with ≥2 edges between grants.
4. Reset mid-grant: GNT0 high and REQ0 high, then RESET_N=0 for one edge -> GNT0=0 and BUSY=0 after that edge, no GAP.
5. Timeout (macro defined, TIMEOUT=4): REQ0 held high, REQ1 high -> GNT0 high exactly 4 cycles, TIMEOUT_ERR=1, then GAP, then GNT1.
6. Clear: CLR_ERR=1 with TIMEOUT_ERR=1 -> TIMEOUT_ERR=0. CLR_ERR=1 on the same edge as a new timeout -> TIMEOUT_ERR stays 1. Without the macro, REQ0 held for 300 cycles -> GNT0 held for all 300 cycles and TIMEOUT_ERR=0.
